// File: rtl/shift_seq_pkg.sv
// Shared types and constants for the shift-register command sequencer.
//   state_t     : sequencer FSM states
//   SHIFT_RIGHT : cmd_dir / sr_shift_type value for a right shift (fill enters MSB)
//   SHIFT_LEFT  : cmd_dir / sr_shift_type value for a left shift (fill enters LSB)
package shift_seq_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT,
        S_DONE
    } state_t;

    localparam logic SHIFT_RIGHT = 1'b0;
    localparam logic SHIFT_LEFT  = 1'b1;

endpackage

// File: rtl/down_counter.sv
// Loadable down-counter used to pace the shift phase.
//   clk, rst  : clock, asynchronous active-low reset
//   load      : load cnt with load_val (has priority over dec)
//   dec       : decrement cnt by one
//   load_val  : value to load
//   cnt       : current count
//   is_one    : cnt == 1, i.e. the current cycle is the last shift
module down_counter #(
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic          dec,
    input  logic [CW-1:0] load_val,
    output logic [CW-1:0] cnt,
    output logic          is_one
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec) begin
            cnt <= cnt - CW'(1);
        end
    end

    assign is_one = (cnt == CW'(1));

endmodule

// File: rtl/shift_seq.sv
// Command sequencer driving a parallel-load shift register.
// Accepts (word, count, dir, fill) over a valid/ready handshake, loads the
// word, issues count single-bit shifts (count clamped to N), samples the
// register output and pulses done.
//   clk, rst          : clock, asynchronous active-low reset
//   cmd_valid/ready   : command handshake (ready only in IDLE)
//   cmd_data/count/dir/fill : command fields
//   abort             : terminate an active command (LOAD or SHIFT)
//   sr_*              : shift-register control / data pins
//   sr_data_out       : shift-register parallel output
//   done              : one-cycle completion pulse
//   res_data          : register contents captured in DONE
//   res_aborted       : last command ended by abort
module shift_seq
    import shift_seq_pkg::*;
#(
    parameter int N  = 8,
    parameter int CW = $clog2(N + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [N-1:0]  cmd_data,
    input  logic [CW-1:0] cmd_count,
    input  logic          cmd_dir,
    input  logic          cmd_fill,
    input  logic          abort,
    output logic          sr_ld,
    output logic          sr_shift_en,
    output logic          sr_shift_type,
    output logic          sr_ser_in,
    output logic [N-1:0]  sr_data_in,
    input  logic [N-1:0]  sr_data_out,
    output logic          done,
    output logic [N-1:0]  res_data,
    output logic          res_aborted
);

    state_t        state, state_nxt;
    logic [N-1:0]  word_q;
    logic          dir_q;
    logic          fill_q;
    logic [CW-1:0] count_q;
    logic          abort_q;
    logic          accept;
    logic [CW-1:0] count_clamped;
    logic          cnt_load;
    logic          cnt_dec;
    logic [CW-1:0] cnt;
    logic          cnt_is_one;

    assign accept        = cmd_valid && (state == S_IDLE);
    assign count_clamped = (cmd_count > CW'(N)) ? CW'(N) : cmd_count;

    down_counter #(
        .CW (CW)
    ) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .dec      (cnt_dec),
        .load_val (count_q),
        .cnt      (cnt),
        .is_one   (cnt_is_one)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            word_q      <= '0;
            dir_q       <= SHIFT_RIGHT;
            fill_q      <= 1'b0;
            count_q     <= '0;
            abort_q     <= 1'b0;
            res_data    <= '0;
            res_aborted <= 1'b0;
        end else begin
            if (accept) begin
                word_q  <= cmd_data;
                dir_q   <= cmd_dir;
                fill_q  <= cmd_fill;
                count_q <= count_clamped;
                abort_q <= 1'b0;
            end else if (abort && (state == S_LOAD || state == S_SHIFT)) begin
                abort_q <= 1'b1;
            end
            if (state == S_DONE) begin
                res_data    <= sr_data_out;
                res_aborted <= abort_q;
            end
        end
    end

    always_comb begin
        state_nxt     = state;
        cmd_ready     = 1'b0;
        sr_ld         = 1'b0;
        sr_shift_en   = 1'b0;
        sr_shift_type = 1'b0;
        done          = 1'b0;
        cnt_load      = 1'b0;
        cnt_dec       = 1'b0;
        unique case (state)
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (accept) state_nxt = S_LOAD;
            end
            S_LOAD: begin
                sr_ld         = 1'b1;
                sr_shift_type = dir_q;
                cnt_load      = 1'b1;
                if (abort || count_q == '0) state_nxt = S_DONE;
                else                        state_nxt = S_SHIFT;
            end
            S_SHIFT: begin
                // abort suppresses the shift in the cycle it is seen
                sr_shift_en   = !abort;
                sr_shift_type = dir_q;
                cnt_dec       = 1'b1;
                if (abort || cnt_is_one) state_nxt = S_DONE;
            end
            S_DONE: begin
                done          = 1'b1;
                sr_shift_type = dir_q;
                state_nxt     = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign sr_data_in = word_q;
    assign sr_ser_in  = fill_q;

endmodule

// File: tb/tb_shift_seq.sv
module tb_shift_seq;

    localparam int N  = 8;
    localparam int CW = $clog2(N + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [N-1:0]  cmd_data = '0;
    logic [CW-1:0] cmd_count = '0;
    logic          cmd_dir = 1'b0;
    logic          cmd_fill = 1'b0;
    logic          abort = 1'b0;
    logic          sr_ld, sr_shift_en, sr_shift_type, sr_ser_in;
    logic [N-1:0]  sr_data_in;
    logic [N-1:0]  sr_data_out;
    logic          done;
    logic [N-1:0]  res_data;
    logic          res_aborted;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    shift_seq #(
        .N  (N),
        .CW (CW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_data      (cmd_data),
        .cmd_count     (cmd_count),
        .cmd_dir       (cmd_dir),
        .cmd_fill      (cmd_fill),
        .abort         (abort),
        .sr_ld         (sr_ld),
        .sr_shift_en   (sr_shift_en),
        .sr_shift_type (sr_shift_type),
        .sr_ser_in     (sr_ser_in),
        .sr_data_in    (sr_data_in),
        .sr_data_out   (sr_data_out),
        .done          (done),
        .res_data      (res_data),
        .res_aborted   (res_aborted)
    );

    // Downstream parallel-load shift register the sequencer drives.
    logic [N-1:0] sr_q;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)             sr_q <= '0;
        else if (sr_ld)       sr_q <= sr_data_in;
        else if (sr_shift_en) sr_q <= sr_shift_type ? {sr_q[N-2:0], sr_ser_in}
                                                     : {sr_ser_in, sr_q[N-1:1]};
    end
    assign sr_data_out = sr_q;

    // Reference: word after n single-bit shifts in the given direction.
    function automatic logic [N-1:0] ref_shift(input logic [N-1:0] d, input int n,
                                               input logic dir, input logic fill);
        logic [N-1:0] r = d;
        for (int k = 0; k < n; k++) begin
            if (dir) r = (r << 1) | N'(fill);
            else     r = (r >> 1) | (N'(fill) << (N - 1));
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Waits for cmd_ready (bounded), presents the command and lets it be accepted.
    task automatic issue(input logic [N-1:0] d, input int c, input logic dir, input logic fill);
        int w = 0;
        @(negedge clk);
        while (!cmd_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        chk("ready_before_issue", 32'(cmd_ready), 32'd1);
        cmd_data  = d;
        cmd_count = CW'(c);
        cmd_dir   = dir;
        cmd_fill  = fill;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Counts cycles after accept until done; abort_at>0 raises abort in that SHIFT cycle.
    task automatic observe(input int abort_at, output int lat, output int shifts);
        lat    = -1;
        shifts = 0;
        for (int j = 1; j <= 40; j++) begin
            @(negedge clk);
            abort = (abort_at > 0) && (j == abort_at + 1);
            #1;
            if (sr_shift_en) shifts++;
            if (done) begin
                lat = j;
                break;
            end
        end
        abort = 1'b0;
    endtask

    task automatic run(input string tag, input logic [N-1:0] d, input int c,
                       input logic dir, input logic fill, input int abort_at);
        int ceff, lat, sh, exp_sh, exp_lat;
        ceff = (c > N) ? N : c;
        issue(d, c, dir, fill);
        cmd_valid = 1'b0;
        observe(abort_at, lat, sh);
        exp_sh  = (abort_at > 0) ? abort_at - 1 : ceff;
        exp_lat = (abort_at > 0) ? abort_at + 2 : ceff + 2;
        chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_shifts"}, 32'(sh), 32'(exp_sh));
        @(negedge clk);
        chk({tag, "_res_data"}, 32'(res_data), 32'(ref_shift(d, exp_sh, dir, fill)));
        chk({tag, "_res_aborted"}, 32'(res_aborted), 32'(abort_at > 0));
    endtask

    initial begin
        int lat, sh, c, ab;
        logic [N-1:0] d;
        logic dr, fl;

        #12;
        chk("rst_ready", 32'(cmd_ready), 32'd1);
        chk("rst_outs", 32'({sr_ld, sr_shift_en, sr_shift_type, sr_ser_in, done, res_aborted}), 32'd0);
        chk("rst_data", 32'({sr_data_in, res_data}), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        run("right",  8'hA5, 3,  1'b0, 1'b0, 0);
        run("left",   8'h81, 2,  1'b1, 1'b1, 0);
        run("zero",   8'h3C, 0,  1'b0, 1'b0, 0);
        run("clamp",  8'h00, 12, 1'b0, 1'b1, 0);
        run("abort",  8'hF0, 6,  1'b1, 1'b0, 2);
        run("max",    8'h5A, 15, 1'b1, 1'b0, 0);

        // Busy: cmd_valid stays high with a second command during the first.
        issue(8'h55, 4, 1'b0, 1'b0);
        cmd_data  = 8'h0F;
        cmd_count = CW'(1);
        cmd_dir   = 1'b1;
        cmd_fill  = 1'b1;
        observe(0, lat, sh);
        chk("busy_a_latency", 32'(lat), 32'd6);
        chk("busy_a_shifts", 32'(sh), 32'd4);
        @(negedge clk);
        chk("busy_ready_back", 32'(cmd_ready), 32'd1);
        chk("busy_a_res", 32'(res_data), 32'(ref_shift(8'h55, 4, 1'b0, 1'b0)));
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        observe(0, lat, sh);
        chk("busy_b_latency", 32'(lat), 32'd3);
        @(negedge clk);
        chk("busy_b_res", 32'(res_data), 32'(ref_shift(8'h0F, 1, 1'b1, 1'b1)));

        // Reset mid-SHIFT.
        issue(8'hC3, 6, 1'b1, 1'b1);
        cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("midrst_ready", 32'(cmd_ready), 32'd1);
        chk("midrst_outs", 32'({sr_ld, sr_shift_en, sr_shift_type, sr_ser_in, done, res_aborted}), 32'd0);
        chk("midrst_data", 32'({sr_data_in, res_data}), 32'd0);
        begin
            int seen = 0;
            repeat (10) begin
                @(negedge clk);
                if (done) seen++;
            end
            chk("midrst_no_done", 32'(seen), 32'd0);
        end
        rst = 1'b1;
        run("after_rst", 8'h96, 5, 1'b0, 1'b1, 0);

        // Randomized commands.
        for (int i = 0; i < 25; i++) begin
            d  = N'($urandom);
            c  = int'($urandom_range(0, 15));
            dr = 1'($urandom);
            fl = 1'($urandom);
            ab = 0;
            if (c > 0 && $urandom_range(0, 3) == 0)
                ab = int'($urandom_range(1, (c > N) ? N : c));
            run("rand", d, c, dr, fl, ab);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/shift_seq.md
# shift_seq

Command sequencer that sits directly upstream of the parallel-load shift register and drives its `ld`, `shift_en`, `shift_type`, `ser_in` and `data_in` pins. It accepts a command through a valid/ready handshake: word, shift count, direction and fill bit. It then loads the word, issues the requested number of single-bit shifts, samples the register's parallel output, and reports completion with a one-cycle `done` pulse. The sequencer and the shift register share `clk` and `rst`.

## Interface
- `N`, default 8: word width, equal to the shift register's `N`.
- `CW`, default `$clog2(N+1)`: width of the shift-count field.

- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  sequencer idle; a command is accepted when `cmd_valid` and `cmd_ready` are both high at a rising edge.
- `cmd_data`  in  N  word to load.
- `cmd_count`  in  CW  number of shifts, 0..2^CW-1.
- `cmd_dir`  in  1  0 = shift right (fill enters MSB), 1 = shift left (fill enters LSB).
- `cmd_fill`  in  1  serial fill bit.
- `abort`  in  1  terminates an active command.
- `sr_ld`, `sr_shift_en`, `sr_shift_type`, `sr_ser_in`  out  1 each  shift-register controls.
- `sr_data_in`  out  N  shift-register parallel load word.
- `sr_data_out`  in  N  shift-register parallel output.
- `done`  out  1  one-cycle completion pulse.
- `res_data`  out  N  final register contents, held until the next `done`.
- `res_aborted`  out  1  last command ended by `abort`, held until the next `done`.

## Operation
- The FSM has four states: IDLE, LOAD, SHIFT, DONE.
- **IDLE**
  - `cmd_ready`=1.
  - On accept, latch data, dir and fill; latch count clamped to N; go to LOAD.
- **LOAD** (one cycle)
  - `sr_ld`=1, `sr_shift_en`=0.
  - If the clamped count is 0, go to DONE.
  - Otherwise load the down-counter with the count and go to SHIFT.
- **SHIFT**
  - `sr_shift_en`=1 and `sr_shift_type`=dir for each cycle.
  - The counter decrements every cycle; on the cycle it equals 1, go to DONE.
- **DONE** (one cycle)
  - `done`=1.
  - `res_data` ← `sr_data_out`.
  - `res_aborted` ← abort flag.
  - Go to IDLE.
- `sr_data_in` always drives the latched word. `sr_ser_in` always drives the latched fill bit.
- `sr_shift_type` outputs the latched dir in every state except IDLE; in IDLE it is 0.
- **abort** (sampled in LOAD or SHIFT)
  - Sets the abort flag and forces the next state to DONE.
  - In SHIFT, `sr_shift_en` is gated low that cycle, so the aborting cycle does not shift.
  - In LOAD, the load still occurs.
  - Ignored in IDLE and DONE.
- `cmd_valid` while `cmd_ready`=0 is ignored; it is not queued.
- Reset value of `cmd_ready` is 1. Every other output resets to 0, and the FSM resets to IDLE.

## Timing
- Accept at edge k. LOAD occupies cycle k+1. SHIFT occupies cycles k+2 .. k+1+C. DONE occurs at cycle k+2+C. `cmd_ready` rises at k+3+C.
- Latency from accept to `done` is C+2 cycles. Throughput is one command per C+3 cycles.
- All control outputs are Moore, decoded from registered state. The only exception is `sr_shift_en`, which is additionally gated by `abort`.
- Reset asserted mid-command: the sequencer returns to IDLE asynchronously. The shift register clears on the same reset, and no `done` is issued.

## Structure
- Package `shift_seq_pkg` holds:
  - the state enum;
  - `SHIFT_RIGHT`=1'b0 and `SHIFT_LEFT`=1'b1.
- One sub-module, `down_counter #(CW)`, with inputs `load`, `dec`, `load_val` and outputs `cnt`, `is_one`. It uses the same asynchronous active-low reset.

## Test plan
- **Right shift:** data 0xA5, count 3, right, fill 0 → `done` 5 cycles after accept, `res_data`=0x14, `res_aborted`=0.
- **Left shift with fill:** data 0x81, count 2, left, fill 1 → `res_data`=0x07, `done` after 4 cycles.
- **Zero count:** count 0, data 0x3C → no `sr_shift_en`, `done` 2 cycles after accept, `res_data`=0x3C.
- **Count clamp:** count 12 (N=8), right, fill 1, data 0x00 → exactly 8 shift cycles, `res_data`=0xFF, `done` after 10 cycles.
- **Abort:** data 0xF0, count 6, left, fill 0, `abort` on the 2nd SHIFT cycle → one shift only, `res_data`=0xE0, `res_aborted`=1.
- **Busy and reset:** `cmd_valid` held high during SHIFT → second command accepted only after `cmd_ready` returns. `rst` low mid-SHIFT → `cmd_ready`=1 and all other outputs 0 immediately, no `done`.
